// File: rtl/display_pkg.sv
// Shared constants and types for the score display path: digit count, blank code,
// score ceiling, converter state encoding and the per-digit anode patterns.
package display_pkg;

    localparam int         NUM_DIGITS  = 4;
    localparam logic [3:0] BLANK_DIGIT = 4'hF;
    localparam int         MAX_SCORE   = 9999;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        COMMIT
    } conv_state_t;

    // Index 0 = ones ... 3 = thousands; active-low, one-hot-low.
    localparam logic [3:0] ANODE_PAT [NUM_DIGITS] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

endpackage

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter: one shift per clock, with a one-deep pending
// slot so strobes arriving mid-conversion are kept (last one wins).
module bin_to_bcd_seq
    import display_pkg::*;
#(
    parameter int SCORE_W = 14
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [SCORE_W-1:0] score,
    input  logic               score_valid,
    output logic               busy,
    output logic               done,
    output logic [15:0]        bcd
);

    localparam int CNT_W = $clog2(SCORE_W + 1);
    localparam int SR_W  = 16 + SCORE_W;

    conv_state_t        state, state_nxt;
    logic [CNT_W-1:0]   iter_cnt;
    logic               pending;
    logic [SCORE_W-1:0] pend_score;
    logic [SR_W-1:0]    sr;
    logic               start;

    function automatic logic [SCORE_W-1:0] sat_score(input logic [SCORE_W-1:0] s);
        if (32'(s) > 32'(MAX_SCORE)) return SCORE_W'(MAX_SCORE);
        return s;
    endfunction

    function automatic logic [15:0] dabble(input logic [15:0] b);
        logic [15:0] r;
        r = b;
        for (int i = 0; i < 4; i++) begin
            if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    assign start = (state == IDLE) && (score_valid || pending);
    assign busy  = (state != IDLE) || pending;
    assign bcd   = sr[SR_W-1:SCORE_W];

    always_comb begin
        state_nxt = state;
        done      = 1'b0;
        case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT:   if (iter_cnt == CNT_W'(1)) state_nxt = COMMIT;
            COMMIT: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            iter_cnt <= '0;
            pending  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (start) begin
                iter_cnt <= CNT_W'(SCORE_W);
                pending  <= 1'b0;
            end else if (state == SHIFT) begin
                iter_cnt <= iter_cnt - 1'b1;
            end
            if (score_valid && (state != IDLE)) pending <= 1'b1;
        end
    end

    // A fresh strobe in IDLE takes priority over an older pending value.
    always_ff @(posedge clk) begin
        if (state == IDLE) begin
            if (score_valid)  sr <= {16'd0, sat_score(score)};
            else if (pending) sr <= {16'd0, sat_score(pend_score)};
        end else if (state == SHIFT) begin
            sr <= {dabble(sr[SR_W-1:SCORE_W]), sr[SCORE_W-1:0]} << 1;
        end
        if (score_valid && (state != IDLE)) pend_score <= score;
    end

endmodule

// File: rtl/score_display_mux.sv
// Score to 4-digit multiplexed 7-segment feed: BCD conversion plus anode scanning.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zeros (ones never blanked).
module score_display_mux
    import display_pkg::*;
#(
    parameter int CLK_HZ     = 100_000_000,
    parameter int REFRESH_HZ = 1000,
    parameter int SCORE_W    = 14
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [SCORE_W-1:0] score,
    input  logic               score_valid,
    output logic               busy,
    output logic [3:0]         digit,
    output logic [3:0]         an
);

    localparam int DWELL  = CLK_HZ / REFRESH_HZ;
    localparam int TICK_W = (DWELL > 1) ? $clog2(DWELL) : 1;

    logic [TICK_W-1:0] tick_cnt;
    logic              tick;
    logic [1:0]        idx, idx_nxt;
    logic [15:0]       disp, disp_nxt;
    logic              conv_done;
    logic [15:0]       conv_bcd;

    bin_to_bcd_seq #(.SCORE_W(SCORE_W)) u_conv (
        .clk         (clk),
        .rst         (rst),
        .score       (score),
        .score_valid (score_valid),
        .busy        (busy),
        .done        (conv_done),
        .bcd         (conv_bcd)
    );

    function automatic logic [3:0] pick_digit(input logic [15:0] d, input logic [1:0] i);
        logic [3:0] nib;
        nib = d[{i, 2'b00} +: 4];
`ifdef LEADING_ZERO_BLANK_EN
        case (i)
            2'd3:    if (d[15:12] == 4'd0) nib = BLANK_DIGIT;
            2'd2:    if (d[15:8]  == 8'd0) nib = BLANK_DIGIT;
            2'd1:    if (d[15:4]  == 12'd0) nib = BLANK_DIGIT;
            default: nib = d[3:0];
        endcase
`endif
        return nib;
    endfunction

    assign tick     = (tick_cnt == TICK_W'(DWELL - 1));
    assign idx_nxt  = tick ? idx + 2'd1 : idx;
    // Outputs look ahead at the committed value so a COMMIT on a tick edge shows at once.
    assign disp_nxt = conv_done ? conv_bcd : disp;

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt <= '0;
            idx      <= 2'd0;
            disp     <= 16'd0;
            an       <= ANODE_PAT[0];
            digit    <= 4'd0;
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
            idx      <= idx_nxt;
            disp     <= disp_nxt;
            an       <= ANODE_PAT[idx_nxt];
            digit    <= pick_digit(disp_nxt, idx_nxt);
        end
    end

endmodule

// File: tb/tb_score_display_mux.sv
// Directed bench for score_display_mux with a 4-cycle dwell (CLK_HZ=1000, REFRESH_HZ=250).
module tb_score_display_mux;

    logic        clk = 1'b0;
    logic        rst;
    logic [13:0] score;
    logic        score_valid;
    logic        busy;
    logic [3:0]  digit;
    logic [3:0]  an;

    int n_checks = 0;
    int n_pass   = 0;

    logic [3:0] frm [4];
    logic [3:0] anp [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [15:0] EXP0   = 16'hFFF0;
    localparam logic [15:0] EXP7   = 16'hFFF7;
    localparam logic [15:0] EXP222 = 16'hF222;
`else
    localparam logic [15:0] EXP0   = 16'h0000;
    localparam logic [15:0] EXP7   = 16'h0007;
    localparam logic [15:0] EXP222 = 16'h0222;
`endif

    always #5 clk = ~clk;

    score_display_mux #(
        .CLK_HZ     (1000),
        .REFRESH_HZ (250),
        .SCORE_W    (14)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .score       (score),
        .score_valid (score_valid),
        .busy        (busy),
        .digit       (digit),
        .an          (an)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic clear_frame();
        for (int i = 0; i < 4; i++) frm[i] = 4'hE;
    endtask

    task automatic grab();
        case (an)
            4'b1110: frm[0] = digit;
            4'b1101: frm[1] = digit;
            4'b1011: frm[2] = digit;
            4'b0111: frm[3] = digit;
            default: ;
        endcase
    endtask

    task automatic capture_frame();
        clear_frame();
        repeat (16) begin
            @(negedge clk);
            grab();
        end
    endtask

    task automatic check_frame(input string tag, input logic [15:0] exp);
        for (int i = 0; i < 4; i++)
            check($sformatf("%s_pos%0d", tag, i), 32'(frm[i]), 32'(exp[4*i +: 4]));
    endtask

    // Leaves the bench at the negedge of cycle 1 (strobe sampled at the end of cycle 0).
    task automatic pulse(input logic [13:0] v);
        @(negedge clk);
        score       = v;
        score_valid = 1'b1;
        @(negedge clk);
        score_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int busy_hi;
        rst         = 1'b1;
        score       = '0;
        score_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        check("rst_busy", 32'(busy), 32'd0);
        check("rst_an", 32'(an), 32'hE);
        check("rst_digit", 32'(digit), 32'd0);
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            check($sformatf("idle_an_k%0d", k), 32'(an), 32'(anp[(k/4)%4]));
            check($sformatf("idle_digit_k%0d", k), 32'(digit), 32'(EXP0[4*((k/4)%4) +: 4]));
        end

        pulse(14'd1234);
        check("b1234_busy_c1", 32'(busy), 32'd1);
        repeat (14) @(negedge clk);
        check("b1234_busy_c15", 32'(busy), 32'd1);
        @(negedge clk);
        check("b1234_busy_c16", 32'(busy), 32'd0);
        capture_frame();
        check_frame("s1234", 16'h1234);

        pulse(14'd12000);
        repeat (15) @(negedge clk);
        check("sat_busy", 32'(busy), 32'd0);
        capture_frame();
        check_frame("sat", 16'h9999);

        @(negedge clk);
        score       = 14'd5678;
        score_valid = 1'b1;
        busy_hi     = 0;
        clear_frame();
        for (int cyc = 1; cyc <= 31; cyc++) begin
            @(negedge clk);
            if (busy) busy_hi++;
            if (cyc >= 16) grab();
            score_valid = (cyc == 3) || (cyc == 5);
            if (cyc == 3) score = 14'd111;
            if (cyc == 5) score = 14'd222;
        end
        check("ovl_busy_cycles", 32'(busy_hi), 32'd31);
        check_frame("ovl_first", 16'h5678);
        clear_frame();
        @(negedge clk);
        check("ovl_busy_c32", 32'(busy), 32'd0);
        grab();
        repeat (15) begin
            @(negedge clk);
            grab();
        end
        check_frame("ovl_second", EXP222);

        pulse(14'd7);
        repeat (15) @(negedge clk);
        capture_frame();
        check_frame("s7", EXP7);

        pulse(14'd4321);
        repeat (7) @(negedge clk);
        check("rstmid_busy_c8", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("rstmid_busy", 32'(busy), 32'd0);
        check("rstmid_an", 32'(an), 32'hE);
        check("rstmid_digit", 32'(digit), 32'd0);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("rstmid_busy_later", 32'(busy), 32'd0);
        capture_frame();
        check_frame("rstmid", EXP0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
